// File: rtl/qam16_sym_pack.sv
// rtl/qam16_sym_pack.sv - packs 16-QAM symbol pairs into bytes and buffers them in an FWFT FIFO
// Optional pushed/dropped byte counters: define QAM16_PACK_CNT_EN
module qam16_sym_pack #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             valid_x,
  input  logic [3:0]       x,
  input  logic             flush,
  output logic             valid_o,
  output logic [7:0]       data_o,
  input  logic             ready_i,
  output logic [LVL_W-1:0] level,
  output logic             half,
  output logic             ovf
`ifdef QAM16_PACK_CNT_EN
  ,
  output logic [15:0]      byte_cnt,
  output logic [7:0]       drop_cnt
`endif
);
  localparam int AW = LVL_W - 1;

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t           state, state_nx;
  logic [3:0]       nib;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [LVL_W-1:0] wr_ptr, rd_ptr, wr_nx, rd_nx, cnt_nx;
  logic             push_req, push, pop, full;
  logic [7:0]       push_byte;

  always_comb begin
    state_nx  = state;
    push_req  = 1'b0;
    push_byte = {nib, x};
    case (state)
      S_EMPTY: if (valid_x) state_nx = S_EMPTY == S_EMPTY ? S_HOLD : S_HOLD;
      S_HOLD: begin
        // valid_x has priority over flush; flush pads the low nibble with zeros
        if (valid_x) begin
          state_nx = S_EMPTY;
          push_req = 1'b1;
        end else if (flush) begin
          state_nx  = S_EMPTY;
          push_req  = 1'b1;
          push_byte = {nib, 4'h0};
        end
      end
      default: state_nx = S_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_EMPTY;
      nib   <= 4'h0;
    end else begin
      state <= state_nx;
      if (state == S_EMPTY && valid_x) nib <= x;
    end
  end

  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop    = valid_o && ready_i;
  assign push   = push_req && (!full || pop);
  assign wr_nx  = wr_ptr + {{AW{1'b0}}, push};
  assign rd_nx  = rd_ptr + {{AW{1'b0}}, pop};
  assign cnt_nx = wr_nx - rd_nx;
  assign level  = wr_ptr - rd_ptr;
  assign half   = (state == S_HOLD);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_byte;
  end

  // The head register is loaded from the next read slot, or bypassed from the
  // incoming byte when that byte lands directly at the head.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_o <= 1'b0;
      data_o  <= 8'h00;
      ovf     <= 1'b0;
    end else begin
      wr_ptr  <= wr_nx;
      rd_ptr  <= rd_nx;
      valid_o <= (cnt_nx != '0);
      if (cnt_nx != '0) begin
        if (push && (wr_ptr[AW-1:0] == rd_nx[AW-1:0]))
          data_o <= push_byte;
        else
          data_o <= mem[rd_nx[AW-1:0]];
      end
      if (push_req && !push) ovf <= 1'b1;
    end
  end

`ifdef QAM16_PACK_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      byte_cnt <= 16'h0000;
      drop_cnt <= 8'h00;
    end else begin
      byte_cnt <= byte_cnt + {15'd0, push};
      if (push_req && !push && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_qam16_sym_pack.sv
// tb/tb_qam16_sym_pack.sv - scoreboard bench for qam16_sym_pack
module tb_qam16_sym_pack;
  localparam int DEPTH = 8;

  logic       CLK, RST;
  logic       valid_x, flush, ready_i;
  logic [3:0] x;
  logic       valid_o, half, ovf;
  logic [7:0] data_o;
  logic [3:0] level;
`ifdef QAM16_PACK_CNT_EN
  logic [15:0] byte_cnt;
  logic [7:0]  drop_cnt;
`endif

  qam16_sym_pack #(.FIFO_DEPTH(DEPTH), .LVL_W(4)) dut (
    .CLK(CLK), .RST(RST), .valid_x(valid_x), .x(x), .flush(flush),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .level(level), .half(half), .ovf(ovf)
`ifdef QAM16_PACK_CNT_EN
    , .byte_cnt(byte_cnt), .drop_cnt(drop_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_data;
  logic [3:0] m_nib;
  logic       m_half, m_ovf;
  int         m_bcnt, m_dcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_data = 8'h00;
    m_nib  = 4'h0;
    m_half = 1'b0;
    m_ovf  = 1'b0;
    m_bcnt = 0;
    m_dcnt = 0;
  endtask

  task automatic do_reset();
    valid_x = 1'b0; x = 4'h0; flush = 1'b0; ready_i = 1'b0;
    RST = 1'b0;
    #1;
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_data_o", data_o, 8'h00);
    check("rst_level", level, 4'd0);
    check("rst_half", half, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    model_clear();
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  // Drive one cycle of inputs, check the DUT against the model, then advance the model.
  task automatic step(input logic vx, input logic [3:0] xv, input logic fl, input logic rdy);
    logic       pop;
    logic [7:0] b;
    valid_x = vx; x = xv; flush = fl; ready_i = rdy;
    @(negedge CLK);
    check("valid_o", valid_o, m_q.size() != 0);
    check("data_o", data_o, m_data);
    check("level", level, m_q.size());
    check("half", half, m_half);
    check("ovf", ovf, m_ovf);
`ifdef QAM16_PACK_CNT_EN
    check("byte_cnt", byte_cnt, m_bcnt[15:0]);
    check("drop_cnt", drop_cnt, m_dcnt[7:0]);
`endif
    pop = (m_q.size() != 0) && rdy;
    if (pop) begin
      check("byte_out", data_o, m_q[0]);
      void'(m_q.pop_front());
    end
    if (m_half && (vx || fl)) begin
      b = vx ? {m_nib, xv} : {m_nib, 4'h0};
      if (m_q.size() < DEPTH) begin
        m_q.push_back(b);
        m_bcnt++;
      end else begin
        m_ovf = 1'b1;
        if (m_dcnt != 255) m_dcnt++;
      end
    end
    if (vx) begin
      if (!m_half) m_nib = xv;
      m_half = !m_half;
    end else if (fl) begin
      m_half = 1'b0;
    end
    if (m_q.size() != 0) m_data = m_q[0];
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    RST = 1'b0;
    model_clear();
    do_reset();

    // basic pair
    step(1'b1, 4'hA, 1'b0, 1'b1);
    step(1'b1, 4'h5, 1'b0, 1'b1);
    check("pair_data", data_o, 8'hA5);
    check("pair_valid", valid_o, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("pair_gone", valid_o, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // flush pads a pending nibble; flush while empty is ignored
    step(1'b1, 4'h3, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    check("flush_data", data_o, 8'h30);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("flush_idle", valid_o, 1'b0);
    // flush together with valid_x is ignored
    step(1'b1, 4'h7, 1'b1, 1'b1);
    step(1'b1, 4'h8, 1'b1, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // full FIFO with a pop in the completing cycle
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b1, 4'(i % 16), 1'b0, 1'b0);
    check("full_level", level, 4'd8);
    step(1'b1, 4'h9, 1'b0, 1'b0);
    step(1'b1, 4'hE, 1'b0, 1'b1);
    check("fullpop_level", level, 4'd8);
    check("fullpop_ovf", ovf, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 4'h0, 1'b0, 1'b1);

    // overflow drops bytes and sets sticky ovf
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b1, 4'(i % 16), 1'b0, 1'b0);
    check("ovf_fill_level", level, 4'd8);
    check("ovf_fill_head", data_o, 8'h01);
    step(1'b1, 4'hC, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b0);
    check("ovf_set", ovf, 1'b1);
    check("ovf_level", level, 4'd8);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 4'h0, 1'b0, 1'b1);
    check("ovf_sticky", ovf, 1'b1);

    // continuous stream with toggling ready, crosses pointer wrap
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0, (i % 2) == 0);
`ifdef QAM16_PACK_CNT_EN
    check("stream_byte_cnt", byte_cnt, 16'd20);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b0, 1'b1);
    check("stream_ovf", ovf, 1'b0);

    // async reset mid-stream discards pending nibble and FIFO contents
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 4'(i + 2), 1'b0, 1'b0);
    check("mid_half", half, 1'b1);
    check("mid_level", level, 4'd3);
    do_reset();
    step(1'b1, 4'hF, 1'b0, 1'b1);
    step(1'b1, 4'h1, 1'b0, 1'b1);
    check("post_rst_data", data_o, 8'hF1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
